// File: rtl/serial_to_parallel.sv
// serial_to_parallel
//   Packs a stream of UART receive bytes into one N-bit operand word for the RSA core.
//   The first byte received lands in the MSB byte. The finished word is offered over a
//   valid/ready handshake. Bytes that arrive while a finished word is still waiting are
//   dropped, and the sticky overrun flag is set.
//
//   Optional feature: define S2P_TIMEOUT_EN to discard a partial word after
//   TIMEOUT_CYCLES idle clocks. Without it, a partial word is held indefinitely and
//   timeout_err_o is tied to 0.
//
// Ports
//   clk_i          system clock, all logic on posedge
//   rst_i          synchronous reset, active-high
//   rx_valid_i     one-cycle strobe: rx_byte_i holds a new received byte
//   rx_byte_i      received byte
//   word_ready_i   core takes the word this cycle when word_valid_o=1
//   word_valid_o   word_o holds a complete assembled operand
//   word_o         assembled operand, first byte in word_o[N-1:N-8]
//   busy_o         1 while a partial word is being collected
//   overrun_o      sticky: a byte arrived while a full word was pending
//   timeout_err_o  one-cycle pulse: partial word discarded on idle timeout
module serial_to_parallel #(
    parameter int unsigned N              = 256,
    parameter int unsigned NBYTES_W       = 6,
    parameter int unsigned TIMEOUT_W      = 24,
    parameter int unsigned TIMEOUT_CYCLES = 12_000_000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         rx_valid_i,
    input  logic [7:0]   rx_byte_i,
    input  logic         word_ready_i,
    output logic         word_valid_o,
    output logic [N-1:0] word_o,
    output logic         busy_o,
    output logic         overrun_o,
    output logic         timeout_err_o
);

    localparam int unsigned NBytes = N / 8;
    localparam logic [NBYTES_W-1:0] LastCount = NBYTES_W'(NBytes - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StFull
    } state_e;

    state_e              state_q;
    logic [NBYTES_W-1:0] count_q;
    logic [N-1:0]        word_q;
    logic                word_valid_q;
    logic                busy_q;
    logic                overrun_q;
    logic                timeout_err_q;

`ifdef S2P_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] IdleLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] idle_q;
`else
    // Keeps the timeout parameters referenced when the feature is compiled out.
    logic [TIMEOUT_W-1:0] unused_timeout;
    assign unused_timeout = TIMEOUT_W'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            count_q       <= '0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef S2P_TIMEOUT_EN
            idle_q        <= '0;
`endif
        end else begin
            timeout_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
`ifdef S2P_TIMEOUT_EN
                    idle_q <= '0;
`endif
                    if (rx_valid_i) begin
                        word_q  <= {word_q[N-9:0], rx_byte_i};
                        count_q <= NBYTES_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= StCollect;
                    end
                end
                StCollect: begin
                    if (rx_valid_i) begin
`ifdef S2P_TIMEOUT_EN
                        idle_q <= '0;
`endif
                        word_q <= {word_q[N-9:0], rx_byte_i};
                        if (count_q == LastCount) begin
                            count_q      <= '0;
                            word_valid_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= StFull;
                        end else begin
                            count_q <= count_q + NBYTES_W'(1);
                        end
                    end
`ifdef S2P_TIMEOUT_EN
                    // The TIMEOUT_CYCLES-th consecutive idle cycle drops the partial word.
                    else if (idle_q == IdleLast) begin
                        idle_q        <= '0;
                        count_q       <= '0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= StIdle;
                    end else begin
                        idle_q <= idle_q + TIMEOUT_W'(1);
                    end
`endif
                end
                StFull: begin
`ifdef S2P_TIMEOUT_EN
                    idle_q <= '0;
`endif
                    if (word_ready_i) begin
                        word_valid_q <= 1'b0;
                        if (rx_valid_i) begin
                            // Handshake and new byte in the same cycle: start the next word.
                            word_q  <= {{(N-8){1'b0}}, rx_byte_i};
                            count_q <= NBYTES_W'(1);
                            busy_q  <= 1'b1;
                            state_q <= StCollect;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (rx_valid_i) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;
`ifdef S2P_TIMEOUT_EN
    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Testbench for serial_to_parallel (N=32). Directed scenarios plus a randomized run
// checked against a byte-list model of the assembler.
module tb_serial_to_parallel;

    localparam int unsigned N  = 32;
    localparam int unsigned NB = N / 8;
    localparam int unsigned TO = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         word_ready;
    logic         word_valid;
    logic [N-1:0] word;
    logic         busy;
    logic         overrun;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;

    // Model: bytes of the current partial word, the pending finished word, sticky flag.
    logic [7:0]   m_bytes[$];
    bit           m_pend;
    logic [N-1:0] m_word;
    bit           m_ovr;
    bit           m_to;
    int           m_idle;

    serial_to_parallel #(
        .N             (N),
        .NBYTES_W      (3),
        .TIMEOUT_W     (8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_valid_i   (rx_valid),
        .rx_byte_i    (rx_byte),
        .word_ready_i (word_ready),
        .word_valid_o (word_valid),
        .word_o       (word),
        .busy_o       (busy),
        .overrun_o    (overrun),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    // Applies one cycle of inputs at a negedge, lets the posedge sample them, returns at
    // the next negedge and advances the model by the same cycle.
    task automatic step(input logic v, input logic [7:0] b, input logic r);
        bit was_collect;
        rx_valid   = v;
        rx_byte    = b;
        word_ready = r;
        @(negedge clk);
        rx_valid = 1'b0;
        was_collect = !m_pend && (m_bytes.size() > 0);
        m_to = 1'b0;
        if (rst) begin
            m_bytes.delete();
            m_pend = 1'b0;
            m_word = '0;
            m_ovr  = 1'b0;
        end else if (m_pend) begin
            if (r) begin
                m_pend = 1'b0;
                if (v) m_bytes = {b};
            end else if (v) begin
                m_ovr = 1'b1;
            end
        end else if (v) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == NB) begin
                m_word = '0;
                foreach (m_bytes[i]) m_word = (m_word << 8) | N'(m_bytes[i]);
                m_pend = 1'b1;
                m_bytes.delete();
            end
        end
`ifdef S2P_TIMEOUT_EN
        if (!rst && was_collect && !v) begin
            m_idle++;
            if (m_idle == TO) begin
                m_idle = 0;
                m_bytes.delete();
                m_to = 1'b1;
            end
        end else begin
            m_idle = 0;
        end
`else
        if (was_collect) m_idle = 0;
`endif
    endtask

    task automatic send4(input logic [N-1:0] w, input logic r);
        logic [N-1:0] t;
        t = w;
        for (int i = 0; i < NB; i++) begin
            step(1'b1, t[N-1:N-8], r);
            t = t << 8;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", word_valid); end
        checks++; if (word !== '0) begin errors++; $display("FAIL reset_word got %h want 0", word); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
    endtask

    task automatic test_gapped();
        logic [7:0] bs [4];
        bs = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bs[i], 1'b1);
            if (i < 3) begin
                checks++; if (busy !== 1'b1 || word_valid !== 1'b0) begin
                    errors++; $display("FAIL gap_collect byte %0d busy=%b valid=%b want 1/0", i, busy, word_valid);
                end
                for (int g = 0; g < 3; g++) step(1'b0, 8'h00, 1'b1);
            end
        end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b want 1", word_valid); end
        checks++; if (word !== 32'hDEADBEEF) begin errors++; $display("FAIL gap_word got %h want deadbeef", word); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy got %b want 0", busy); end
        step(1'b0, 8'h00, 1'b1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL gap_drop got %b want 0", word_valid); end
    endtask

    task automatic test_back_to_back_hold();
        send4(32'h01020304, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++; if (word_valid !== 1'b1 || word !== 32'h01020304) begin
                errors++; $display("FAIL hold cycle %0d valid=%b word=%h want 1/01020304", i, word_valid, word);
            end
            step(1'b0, 8'h00, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL hold_drop got %b want 0", word_valid); end
    endtask

    task automatic test_overrun();
        send4(32'h11223344, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        checks++; if (word !== 32'h11223344 || word_valid !== 1'b1) begin
            errors++; $display("FAIL ovr_word got %h/%b want 11223344/1", word, word_valid);
        end
        step(1'b1, 8'h66, 1'b1);
        checks++; if (busy !== 1'b1 || word_valid !== 1'b0) begin
            errors++; $display("FAIL ovr_restart busy=%b valid=%b want 1/0", busy, word_valid);
        end
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h88, 1'b0);
        step(1'b1, 8'h99, 1'b0);
        checks++; if (word !== 32'h66778899 || word_valid !== 1'b1) begin
            errors++; $display("FAIL ovr_next got %h/%b want 66778899/1", word, word_valid);
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_mid_reset();
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        checks++; if ({word_valid, busy, overrun, timeout_err} !== 4'b0 || word !== '0) begin
            errors++; $display("FAIL mrst_outputs got v%b b%b o%b t%b w%h want all 0",
                               word_valid, busy, overrun, timeout_err, word);
        end
        send4(32'h01020304, 1'b0);
        checks++; if (word !== 32'h01020304 || word_valid !== 1'b1) begin
            errors++; $display("FAIL mrst_word got %h/%b want 01020304/1", word, word_valid);
        end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_idle();
        step(1'b1, 8'hC0, 1'b0);
        step(1'b1, 8'hC1, 1'b0);
        for (int i = 1; i <= TO; i++) begin
            step(1'b0, 8'h00, 1'b0);
`ifdef S2P_TIMEOUT_EN
            if (i < TO) begin
                checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                    errors++; $display("FAIL to_early idle %0d t=%b busy=%b want 0/1", i, timeout_err, busy);
                end
            end else begin
                checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL to_pulse t=%b busy=%b want 1/0", timeout_err, busy);
                end
            end
`else
            checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL noto_idle %0d t=%b busy=%b want 0/1", i, timeout_err, busy);
            end
`endif
        end
`ifdef S2P_TIMEOUT_EN
        step(1'b0, 8'h00, 1'b0);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_width got %b want 0", timeout_err); end
        send4(32'h0A0B0C0D, 1'b0);
        checks++; if (word !== 32'h0A0B0C0D || word_valid !== 1'b1) begin
            errors++; $display("FAIL to_next got %h/%b want 0a0b0c0d/1", word, word_valid);
        end
`else
        step(1'b1, 8'hC2, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        checks++; if (word !== 32'hC0C1C2C3 || word_valid !== 1'b1) begin
            errors++; $display("FAIL noto_word got %h/%b want c0c1c2c3/1", word, word_valid);
        end
`endif
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic       v;
        logic       r;
        logic [7:0] b;
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            b = 8'($urandom);
            step(v, b, r);
            checks++; if (word_valid !== m_pend || busy !== (m_bytes.size() > 0) ||
                          overrun !== m_ovr || timeout_err !== m_to) begin
                errors++; $display("FAIL rand_flags cyc %0d v%b b%b o%b t%b want v%b b%b o%b t%b", i,
                                   word_valid, busy, overrun, timeout_err,
                                   m_pend, (m_bytes.size() > 0), m_ovr, m_to);
            end
            if (m_pend) begin
                checks++; if (word !== m_word) begin
                    errors++; $display("FAIL rand_word cyc %0d got %h want %h", i, word, m_word);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_byte    = 8'h00;
        word_ready = 1'b0;
        m_pend     = 1'b0;
        m_word     = '0;
        m_ovr      = 1'b0;
        m_to       = 1'b0;
        m_idle     = 0;
        @(negedge clk);
        test_reset();
        test_gapped();
        test_back_to_back_hold();
        test_overrun();
        test_mid_reset();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
